fifo_wr_arb: RTL and testbench
==============================

# fifo_wr_arb

Round-robin write-port arbiter that shares one small FIFO (2-bit data, full/empty flags) among NREQ producers. It sits between the producers and the FIFO write port. It grants ownership to one requester at a time for bursts of up to MAX_BURST writes, and it stalls on FIFO full. It drives the FIFO's write enable and write data directly.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 2, data width per requester, equal to FIFO wr_data width
- MAX_BURST, 4, maximum consecutive writes per ownership (1..15)
- OW, 2, owner index width, clog2(NREQ)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester write request; data valid while high
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW]
- gnt  out  NREQ  one-hot write acceptance; a write occurs in any cycle where req[i] and gnt[i] are both high
- fifo_full  in  1  FIFO full flag
- fifo_wr_e  out  1  FIFO write enable
- fifo_wr_data  out  DW  FIFO write data
- busy  out  1  high while in OWN state
- cur_owner  out  OW  current owner index; 0 in IDLE

## Operation
- State: FSM {IDLE, OWN}, owner[OW], rr_ptr[OW], bcnt[4].
- Selection function: pick(v, p) returns the first set bit of v scanning p, p+1, …, NREQ-1, 0, … (mod NREQ).
- IDLE: if req != 0, the next state is OWN, with owner = pick(req, rr_ptr) and bcnt = 0. Otherwise stay in IDLE. gnt is 0 in IDLE.
- OWN:
  - gnt[owner] = !fifo_full. All other gnt bits are 0.
  - xfer = req[owner] && gnt[owner].
  - fifo_wr_e = xfer.
  - fifo_wr_data = req_data slice of owner when xfer, else 0.
  - On xfer, bcnt increments.
- OWN exit when !req[owner] or (xfer && bcnt == MAX_BURST-1). On exit:
  - rr_ptr = (owner+1) mod NREQ.
  - If req != 0, stay in OWN with owner = pick(req, (owner+1) mod NREQ) and bcnt = 0. The departing owner naturally ranks last, so there is no idle bubble.
  - Otherwise go to IDLE.
- fifo_full stalls the burst. Ownership is kept, bcnt holds, and there is no timeout. The arbiter never writes while fifo_full is high.
- A requester may deassert req at any time. Its ownership ends at that edge, and the handoff follows the exit rule.
- Requesters other than the owner see gnt = 0 and must hold their data until granted.
- rst forces IDLE, rr_ptr = 0, owner = 0, bcnt = 0. It aborts any burst in progress; no write occurs in the reset cycle.

## Timing
- Reset values (all outputs): gnt = 0, fifo_wr_e = 0, fifo_wr_data = 0, busy = 0, cur_owner = 0.
- Grant latency: req rising in IDLE at cycle 0 produces the first gnt at cycle 1, provided fifo_full is low.
- Throughput: one write per cycle within a burst and across handoffs, with zero bubble cycles.
- gnt, fifo_wr_e and fifo_wr_data are combinational from registered state, req and fifo_full. fifo_full has a same-cycle effect.
- busy and cur_owner are purely registered.
- A write is counted in the FIFO on the clk edge ending a cycle where fifo_wr_e = 1.

## Test plan
- Reset: assert rst for 2 cycles with random req → all outputs 0 during and after reset. The first grant after reset goes to the lowest-index requester.
- Single requester: req[1] held, 6 writes wanted, MAX_BURST = 4 → gnt[1] continuous for 6 cycles starting 1 cycle after req. cur_owner = 1 throughout, including across the burst boundary, and there are no gaps.
- All four requesting continuously with data = index → owner sequence 0,1,2,3,0, four writes each. fifo_wr_data follows 0,0,0,0,1,1,1,1,… with no idle cycles.
- fifo_full high for 3 cycles after the 2nd write of owner 0 → gnt and fifo_wr_e are 0 for those 3 cycles. Owner stays 0, and 2 more writes complete afterwards (4 total) before handoff.
- Owner 0 drops req after 2 writes while req[2] is held → the next cycle has cur_owner = 2, gnt[2] = 1, and the write proceeds with no bubble.
- rst mid-burst (owner 3, bcnt = 2) → next cycle busy = 0, no writes occur. After rst releases with req = 4'b1010, owner = 1.

Source files
------------

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin burst arbiter in front of a FIFO write port (req/req_data/fifo_full in; gnt/fifo_wr_e/fifo_wr_data/busy/cur_owner out)
module fifo_wr_arb #(
  parameter int NREQ = 4,
  parameter int DW = 2,
  parameter int MAX_BURST = 4,
  parameter int OW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  input  logic               fifo_full,
  output logic               fifo_wr_e,
  output logic [DW-1:0]      fifo_wr_data,
  output logic               busy,
  output logic [OW-1:0]      cur_owner
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, rr_q, rr_d, nxt_ptr;
  logic [3:0] bcnt_q, bcnt_d;
  logic st_own, own, xfer, last;
  function automatic logic [OW-1:0] pick(input logic [NREQ-1:0] v, input logic [OW-1:0] p);
    logic [OW-1:0] r, i;
    r = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      i = OW'((int'(p) + k) % NREQ);
      if (v[i]) r = i;
    end
    return r;
  endfunction
  always_comb begin
    st_own = state_q == OWN;
    own = st_own && !rst;
    xfer = own && !fifo_full && req[owner_q];
    gnt = (own && !fifo_full) ? NREQ'(1) << owner_q : '0;
    fifo_wr_e = xfer;
    fifo_wr_data = xfer ? req_data[owner_q*DW +: DW] : '0;
    last = own && (!req[owner_q] || (xfer && bcnt_q == 4'(MAX_BURST - 1)));
    nxt_ptr = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
    state_d = (|req || (st_own && !last)) ? OWN : IDLE;
    owner_d = last ? (|req ? pick(req, nxt_ptr) : '0) : st_own ? owner_q : pick(req, rr_q);
    rr_d = last ? nxt_ptr : rr_q;
    bcnt_d = (last || !st_own) ? '0 : bcnt_q + 4'(xfer);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      bcnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      bcnt_q <= bcnt_d;
    end
  end
  assign busy = st_own;
  assign cur_owner = owner_q;
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed and randomized checks of fifo_wr_arb against a behavioural model
module tb_fifo_wr_arb;
  localparam int NREQ = 4, DW = 2, MAX_BURST = 4, OW = 2;
  logic clk = 0, rst = 0, fifo_full = 0, fifo_wr_e, busy;
  logic [NREQ-1:0] req = '0, gnt;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [DW-1:0] fifo_wr_data;
  logic [OW-1:0] cur_owner;
  int checks = 0, failures = 0;
  fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST), .OW(OW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .fifo_full(fifo_full),
    .fifo_wr_e(fifo_wr_e), .fifo_wr_data(fifo_wr_data), .busy(busy), .cur_owner(cur_owner)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic own;
    logic [OW-1:0] owner;
    logic [OW-1:0] ptr;
    logic [3:0] cnt;
  } mstate_t;
  mstate_t m = '0;
  function automatic logic [OW-1:0] pick_m(input logic [NREQ-1:0] r, input logic [OW-1:0] p);
    for (int i = 0; i < NREQ; i++)
      if (r[OW'((int'(p) + i) % NREQ)]) return OW'((int'(p) + i) % NREQ);
    return '0;
  endfunction
  function automatic mstate_t nxt(input mstate_t s, input logic [NREQ-1:0] r, input logic full, input logic rs);
    mstate_t n;
    logic [OW-1:0] np;
    n = s;
    if (rs) return '0;
    if (!s.own) return (r != 0) ? '{1'b1, pick_m(r, s.ptr), s.ptr, 4'd0} : s;
    n.cnt = s.cnt + 4'(!full && r[s.owner]);
    if (!r[s.owner] || n.cnt == 4'(MAX_BURST)) begin
      np = OW'((int'(s.owner) + 1) % NREQ);
      n = '{r != 0, (r != 0) ? pick_m(r, np) : OW'(0), np, 4'd0};
    end
    return n;
  endfunction
  always @(posedge clk) m <= nxt(m, req, fifo_full, rst);
  logic e_on, e_we;
  logic [NREQ-1:0] e_gnt;
  logic [DW-1:0] e_dat;
  logic [NREQ+DW+OW+1:0] got, exp;
  always_comb begin
    e_on = m.own && !rst && !fifo_full;
    e_we = e_on && req[m.owner];
    e_gnt = e_on ? NREQ'(1) << m.owner : '0;
    e_dat = e_we ? req_data[m.owner*DW +: DW] : '0;
  end
  assign exp = {e_gnt, e_we, e_dat, m.own, m.owner};
  assign got = {gnt, fifo_wr_e, fifo_wr_data, busy, cur_owner};
  task automatic to_next;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1;
    req = '0;
    fifo_full = 0;
    to_next();
    rst = 0;
  endtask
  task automatic test_reset;
    logic [NREQ-1:0] r;
    logic [OW-1:0] lo;
    #1;
    rst = 1;
    req = NREQ'($urandom);
    req_data = (NREQ*DW)'($urandom);
    fifo_full = 1'($urandom);
    to_next();
    req = NREQ'($urandom);
    @(negedge clk);
    checks++;
    if (got !== '0) begin failures++; $display("FAIL reset_during got=%b exp=0", got); end
    to_next();
    rst = 0;
    fifo_full = 0;
    r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    lo = OW'($clog2(r & (~r + 1'b1)));
    req = r;
    @(negedge clk);
    checks++;
    if (got !== '0) begin failures++; $display("FAIL reset_after got=%b exp=0", got); end
    to_next();
    @(negedge clk);
    checks++;
    if (cur_owner !== lo || gnt !== NREQ'(1) << lo || got !== exp) begin
      failures++;
      $display("FAIL reset_first_grant req=%b owner=%0d gnt=%b exp_owner=%0d", r, cur_owner, gnt, lo);
    end
    to_next();
    do_reset();
  endtask
  task automatic test_single;
    req = 4'b0010;
    req_data = (NREQ*DW)'($urandom);
    @(negedge clk);
    checks++;
    if (gnt !== '0 || got !== exp) begin failures++; $display("FAIL single_idle got=%b exp=%b", got, exp); end
    to_next();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0010 || cur_owner !== 2'd1 || fifo_wr_e !== 1'b1 || got !== exp) begin
        failures++;
        $display("FAIL single_burst k=%0d got=%b exp=%b", k, got, exp);
      end
      to_next();
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (fifo_wr_e !== 1'b0 || got !== exp) begin failures++; $display("FAIL single_drop got=%b exp=%b", got, exp); end
    to_next();
    do_reset();
  endtask
  task automatic test_all_rr;
    req = 4'b1111;
    req_data = 8'b11_10_01_00;
    @(negedge clk);
    checks++;
    if (got !== exp) begin failures++; $display("FAIL rr_idle got=%b exp=%b", got, exp); end
    to_next();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if (cur_owner !== OW'(k / 4 % 4) || fifo_wr_data !== DW'(k / 4 % 4) || fifo_wr_e !== 1'b1 || got !== exp) begin
        failures++;
        $display("FAIL rr_seq k=%0d owner=%0d data=%0d we=%b exp_owner=%0d", k, cur_owner, fifo_wr_data, fifo_wr_e, k / 4 % 4);
      end
      to_next();
    end
    do_reset();
  endtask
  task automatic test_full_stall;
    logic [OW-1:0] eo;
    req = 4'b1111;
    req_data = 8'b11_10_01_00;
    @(negedge clk);
    to_next();
    for (int k = 0; k < 9; k++) begin
      fifo_full = (k >= 2 && k < 5);
      eo = (k < 7) ? 2'd0 : 2'd1;
      @(negedge clk);
      checks++;
      if (cur_owner !== eo || fifo_wr_e !== !fifo_full || (fifo_full && gnt !== '0) || got !== exp) begin
        failures++;
        $display("FAIL full_stall k=%0d owner=%0d we=%b gnt=%b exp_owner=%0d", k, cur_owner, fifo_wr_e, gnt, eo);
      end
      to_next();
    end
    fifo_full = 0;
    do_reset();
  endtask
  task automatic test_drop;
    req = 4'b0101;
    req_data = 8'b11_10_01_00;
    @(negedge clk);
    to_next();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) req = 4'b0100;
      @(negedge clk);
      checks++;
      if ((k < 3 && cur_owner !== 2'd0) || (k < 2 && fifo_wr_e !== 1'b1) || (k == 2 && fifo_wr_e !== 1'b0) ||
          (k == 3 && (cur_owner !== 2'd2 || gnt !== 4'b0100 || fifo_wr_e !== 1'b1 || fifo_wr_data !== 2'd2)) || got !== exp) begin
        failures++;
        $display("FAIL drop_handoff k=%0d got=%b exp=%b", k, got, exp);
      end
      to_next();
    end
    do_reset();
  endtask
  task automatic test_rst_mid;
    req = 4'b1000;
    req_data = 8'b11_10_01_00;
    @(negedge clk);
    to_next();
    for (int k = 0; k < 5; k++) begin
      rst = (k == 2);
      if (k == 3) req = 4'b1010;
      @(negedge clk);
      checks++;
      if ((k < 2 && (cur_owner !== 2'd3 || fifo_wr_e !== 1'b1)) || (k == 2 && (gnt !== '0 || fifo_wr_e !== 1'b0)) ||
          (k == 3 && (busy !== 1'b0 || fifo_wr_e !== 1'b0 || gnt !== '0)) ||
          (k == 4 && (busy !== 1'b1 || cur_owner !== 2'd1 || gnt !== 4'b0010)) || got !== exp) begin
        failures++;
        $display("FAIL rst_mid k=%0d got=%b exp=%b", k, got, exp);
      end
      to_next();
    end
    do_reset();
  endtask
  task automatic test_random;
    for (int k = 0; k < 500; k++) begin
      req = NREQ'($urandom) & NREQ'($urandom | $urandom);
      req_data = (NREQ*DW)'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL random k=%0d req=%b full=%b rst=%b got=%b exp=%b", k, req, fifo_full, rst, got, exp);
      end
      to_next();
    end
    do_reset();
  endtask
  initial begin
    test_reset();
    test_single();
    test_all_rr();
    test_full_stall();
    test_drop();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
